// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one single-ported RAM between an icache and a dcache.
// dcache has priority; icache is guaranteed a grant after MAX_DSTREAK dcache wins.
`default_nettype none

module cache_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              ramerr
);

  localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_D = 2'd1,
    SERVE_I = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            ramerr_q, ramerr_d;
  logic            dreq;

  assign dreq   = dREN | dWEN;
  assign iload  = ramload;
  assign dload  = ramload;
  assign ramerr = ramerr_q;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    ramerr_d = ramerr_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;

    case (state_q)
      IDLE: begin
        if (dreq && (!iREN || (streak_q < STREAK_MAX))) begin
          state_d = SERVE_D;
        end else if (iREN) begin
          state_d = SERVE_I;
        end
      end

      SERVE_D: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramREN   = dREN;
        ramWEN   = dWEN;
        if (ramstate == RAM_ACCESS) begin
          dwait   = 1'b0;
          state_d = IDLE;
          // Streak only counts dcache wins that actually delayed a waiting icache.
          if (!iREN) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_ONE;
          end
        end else if (ramstate == RAM_ERROR) begin
          ramerr_d = 1'b1;
          state_d  = IDLE;
        end else if (!dreq) begin
          state_d = IDLE;
        end
      end

      SERVE_I: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (ramstate == RAM_ACCESS) begin
          iwait    = 1'b0;
          streak_d = '0;
          state_d  = IDLE;
        end else if (ramstate == RAM_ERROR) begin
          ramerr_d = 1'b1;
          state_d  = IDLE;
        end else if (!iREN) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      streak_q <= '0;
      ramerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      ramerr_q <= ramerr_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level ownership model of the arbiter.
`default_nettype none

module tb_cache_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic          CLK = 1'b0;
  logic          nRST = 1'b1;
  logic          iREN = 1'b0;
  logic [AW-1:0] iaddr = '0;
  logic          iwait;
  logic [DW-1:0] iload;
  logic          dREN = 1'b0;
  logic          dWEN = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic [DW-1:0] dstore = '0;
  logic          dwait;
  logic [DW-1:0] dload;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload = '0;
  logic [1:0]    ramstate = 2'd0;
  logic          ramerr;

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DSTREAK(MAXS)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Model: who currently owns the RAM (0 none, 1 dcache, 2 icache), how many
  // dcache wins in a row delayed the icache, and whether any error was seen.
  int m_owner  = 0;
  int m_streak = 0;
  bit m_err    = 0;

  always @(negedge CLK) begin
    bit dq;
    bit done;
    dq = dREN | dWEN;
    if (!nRST) begin
      chk("rst_ramREN", ramREN, 0);
      chk("rst_ramWEN", ramWEN, 0);
      chk("rst_iwait", iwait, 1);
      chk("rst_dwait", dwait, 1);
      chk("rst_ramerr", ramerr, 0);
      m_owner  = 0;
      m_streak = 0;
      m_err    = 0;
    end else begin
      done = (ramstate == 2'd2);
      chk("m_ramerr", ramerr, m_err);
      chk("m_one_wait", (!iwait && !dwait), 0);
      if (m_owner == 0) begin
        chk("m_idle_ren", ramREN, 0);
        chk("m_idle_wen", ramWEN, 0);
        chk("m_idle_addr", ramaddr, 0);
        chk("m_idle_store", ramstore, 0);
        chk("m_idle_iwait", iwait, 1);
        chk("m_idle_dwait", dwait, 1);
        if (dq && (!iREN || m_streak < MAXS)) m_owner = 1;
        else if (iREN) m_owner = 2;
      end else if (m_owner == 1) begin
        chk("m_d_ren", ramREN, dREN);
        chk("m_d_wen", ramWEN, dWEN);
        chk("m_d_addr", ramaddr, daddr);
        chk("m_d_store", ramstore, dstore);
        chk("m_d_iwait", iwait, 1);
        chk("m_d_dwait", dwait, !done);
        if (done) chk("m_d_dload", dload, ramload);
        if (done) begin
          m_streak = iREN ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
          m_owner  = 0;
        end else if (ramstate == 2'd3) begin
          m_err   = 1;
          m_owner = 0;
        end else if (!dq) begin
          m_owner = 0;
        end
      end else begin
        chk("m_i_ren", ramREN, iREN);
        chk("m_i_wen", ramWEN, 0);
        chk("m_i_addr", ramaddr, iaddr);
        chk("m_i_dwait", dwait, 1);
        chk("m_i_iwait", iwait, !done);
        if (done) chk("m_i_iload", iload, ramload);
        if (done) begin
          m_streak = 0;
          m_owner  = 0;
        end else if (ramstate == 2'd3) begin
          m_err   = 1;
          m_owner = 0;
        end else if (!iREN) begin
          m_owner = 0;
        end
      end
    end
  end

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = 2'd0;
    next();
    next();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string order;
    int    nd;
    bit    bad;
    #1 nRST = 0;
    #3;
    chk("reset_ramREN", ramREN, 0);
    chk("reset_ramWEN", ramWEN, 0);
    chk("reset_ramaddr", ramaddr, 0);
    chk("reset_ramstore", ramstore, 0);
    chk("reset_waits", {iwait, dwait}, 2'b11);
    chk("reset_ramerr", ramerr, 0);
    next();
    next();
    nRST = 1;
    next();

    // Single icache read with two BUSY cycles
    iREN = 1; iaddr = 32'h100; ramstate = 2'd1;
    #2 chk("t1_idle_ren", ramREN, 0);
    next();
    #2 chk("t1_ren_c1", ramREN, 1);
    chk("t1_addr", ramaddr, 32'h100);
    next();
    #2 chk("t1_ren_c2", ramREN, 1);
    next();
    ramstate = 2'd2; ramload = 32'hDEADBEEF;
    #2 chk("t1_ren_c3", ramREN, 1);
    chk("t1_iwait", iwait, 0);
    chk("t1_iload", iload, 32'hDEADBEEF);
    next();
    iREN = 0; ramstate = 2'd0;
    #2 chk("t1_back_idle", {ramREN, iwait}, 2'b01);
    quiet();

    // Simultaneous requests: dcache first, then icache
    dREN = 1; daddr = 32'h40; iREN = 1; iaddr = 32'h80;
    next();
    ramload = 32'h11111111;
    #2 chk("t2_d_addr", ramaddr, 32'h40);
    next();
    ramstate = 2'd2;
    #2 chk("t2_d_done", {dwait, iwait}, 2'b01);
    chk("t2_dload", dload, 32'h11111111);
    next();
    dREN = 0; ramstate = 2'd0;
    #2 chk("t2_gap", ramREN, 0);
    next();
    ramstate = 2'd2; ramload = 32'h22222222;
    #2 chk("t2_i_addr", ramaddr, 32'h80);
    chk("t2_i_done", {dwait, iwait}, 2'b10);
    chk("t2_iload", iload, 32'h22222222);
    next();
    iREN = 0; ramstate = 2'd0;
    chk("t2_streak", dut.streak_q, 0);
    quiet();

    // Five dcache writes against a waiting icache
    iREN = 1; iaddr = 32'h300; dWEN = 1; daddr = 32'h700; dstore = 32'hA5A5A5A5;
    ramstate = 2'd2; order = ""; nd = 0; bad = 0;
    for (int c = 0; c < 40 && nd < 5; c++) begin
      #2;
      if (!dwait) begin order = {order, "D"}; nd++; end
      if (!iwait) order = {order, "I"};
      if (ramREN && ramaddr == 32'h300 && ramWEN) bad = 1;
      next();
      daddr = 32'h700 + 32'(nd * 4);
      if (nd == 5) begin dWEN = 0; iREN = 0; end
    end
    checks++;
    if (order != "DDDDID") begin
      failures++;
      $display("FAIL t3_grant_order actual=%s required=DDDDID", order);
    end
    chk("t3_no_wen_on_i", bad, 0);
    quiet();

    // Write hits ERROR, then retried
    dWEN = 1; daddr = 32'h200; dstore = 32'h12345678;
    next();
    ramstate = 2'd3;
    #2 chk("t4_wen", {ramWEN, ramREN}, 2'b10);
    chk("t4_store", ramstore, 32'h12345678);
    chk("t4_dwait_err", dwait, 1);
    next();
    ramstate = 2'd0;
    #2 chk("t4_ramerr", ramerr, 1);
    chk("t4_idle", {ramWEN, dwait}, 2'b01);
    next();
    ramstate = 2'd2;
    #2 chk("t4_retry_done", {ramWEN, dwait}, 2'b10);
    next();
    dWEN = 0; ramstate = 2'd0;
    #2 chk("t4_ramerr_sticky", ramerr, 1);
    quiet();

    // icache drops its request while BUSY
    iREN = 1; iaddr = 32'h500; ramstate = 2'd1;
    next();
    #2 chk("t5_granted", ramREN, 1);
    next();
    iREN = 0;
    #2 chk("t5_drop", {ramREN, iwait}, 2'b01);
    next();
    iREN = 1;
    #2 chk("t5_idle", {ramREN, iwait}, 2'b01);
    next();
    #2 chk("t5_regrant", ramREN, 1);
    next();
    iREN = 0;
    quiet();

    // Async reset during a dcache grant
    dREN = 1; daddr = 32'h600; ramstate = 2'd1;
    next();
    #2 chk("t6_granted", ramREN, 1);
    nRST = 0;
    #1 chk("t6_rst_strobes", {ramREN, ramWEN, dwait, ramerr}, 4'b0010);
    next();
    nRST = 1;
    #2 chk("t6_idle_after", ramREN, 0);
    next();
    ramstate = 2'd2;
    #2 chk("t6_regrant", {ramREN, ramaddr}, {1'b1, 32'h600});
    chk("t6_done", dwait, 0);
    next();
    dREN = 0;
    quiet();

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      if ($urandom_range(0, 3) != 0) begin
        r = int'($urandom_range(0, 2));
        dREN = (r == 1);
        dWEN = (r == 2);
        daddr = $urandom;
        dstore = $urandom;
      end
      if ($urandom_range(0, 3) != 0) begin
        iREN = $urandom_range(0, 1) == 1;
        iaddr = $urandom;
      end
      r = int'($urandom_range(0, 99));
      ramstate = (r < 20) ? 2'd0 : (r < 50) ? 2'd1 : (r < 97) ? 2'd2 : 2'd3;
      ramload = $urandom;
      if (c == 1500) begin
        #1 nRST = 0;
        next();
        nRST = 1;
      end else begin
        next();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits directly downstream of the icache/dcache pair and sits between that pair and the single-ported main RAM.
- Arbitrates instruction-fill and data read/write requests onto one RAM port.
- Holds each grant until the RAM completes or errors, then returns the response to the owning cache.
- Gives dcache priority, with a bounded starvation guard for icache.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width.
- MAX_DSTREAK, 4, maximum consecutive dcache grants while an icache request is pending; must be ≥1.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  icache read request.
- iaddr  in  ADDR_W  icache address.
- iwait  out  1  low for exactly one cycle when iload is valid.
- iload  out  DATA_W  icache read data.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request; dREN and dWEN are never high together.
- daddr  in  ADDR_W  dcache address.
- dstore  in  DATA_W  dcache write data.
- dwait  out  1  low for exactly one cycle when the dcache access completes.
- dload  out  DATA_W  dcache read data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data, valid when ramstate==ACCESS.
- ramstate  in  2  RAM status: 0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR.
- ramerr  out  1  sticky RAM-error flag.

Behaviour:

Reset:
- State=IDLE, streak=0, ramerr=0.
- iwait=1, dwait=1, ramREN=0, ramWEN=0.
- ramaddr=0, ramstore=0.

FSM states: IDLE, SERVE_D, SERVE_I. State is registered; the next grant is decided in IDLE from the current-cycle requests.

IDLE:
- Nothing driven to RAM; ramREN=ramWEN=0.
- If a dcache request is pending and (no iREN or streak<MAX_DSTREAK) -> SERVE_D.
- Else if iREN -> SERVE_I.
- Else stay in IDLE.

SERVE_D:
- ramaddr=daddr, ramstore=dstore, ramREN=dREN, ramWEN=dWEN (combinational from the live dcache inputs).
- In a cycle where ramstate==ACCESS: dwait=0 and dload=ramload in that same cycle; -> IDLE.
- On leaving with ACCESS: if iREN is high, streak increments, saturating at MAX_DSTREAK; otherwise streak=0.

SERVE_I:
- ramaddr=iaddr, ramREN=1, ramWEN=0.
- When ramstate==ACCESS: iwait=0, iload=ramload; streak=0; -> IDLE.

Outputs outside a completion cycle:
- iwait=dwait=1.
- iload/dload track ramload but are don't-care.

Common rules:
- FREE/BUSY while granted: hold the grant and keep strobes asserted; no timeout.
- ERROR while granted: owner's wait stays 1, ramerr set to 1 (cleared only by nRST), -> IDLE. The cache's request stays high, so it is re-arbitrated, i.e. retried.
- Requester drops REN/WEN while granted with no ACCESS that cycle: RAM strobes fall combinationally; -> IDLE next cycle; streak unchanged.
- Minimum turnaround: one IDLE cycle between consecutive grants. Back-to-back accesses therefore cost ≥1 extra cycle.
- Both caches requesting in IDLE with streak<MAX_DSTREAK: dcache wins. With streak==MAX_DSTREAK: icache wins.
- Async reset mid-grant: strobes drop immediately and no wait pulse is emitted.
- Exactly one of iwait/dwait may be low in any cycle, never both.

Test Plan:
1. Single icache read, iaddr=0x100, RAM returns BUSY×2 then ACCESS with ramload=0xDEADBEEF -> ramREN high for 3 cycles, then iwait=0 for one cycle with iload=0xDEADBEEF; state back to IDLE.
2. dREN and iREN raised together, streak=0, RAM ACCESS after 1 cycle -> dcache served first (dwait pulse), IDLE cycle, then icache served (iwait pulse); streak ends at 0.
3. dcache issues 5 back-to-back writes while iREN is held high, MAX_DSTREAK=4 -> grant order D,D,D,D,I,D; ramWEN never high during the icache grant.
4. dWEN at daddr=0x200, dstore=0x12345678, ramstate=ERROR -> ramerr=1 and stays 1, dwait stays 1, next access retried and completes on ACCESS; ramerr is still 1 afterwards.
5. iREN dropped while in SERVE_I with ramstate=BUSY -> ramREN=0 in the same cycle, IDLE next cycle, no iwait pulse.
6. nRST asserted while in SERVE_D -> immediately ramREN=ramWEN=0, dwait=1, ramerr=0; after release, state is IDLE and a pending request is granted on the next edge.
